// File: rtl/zorro2_pkg.sv
// Shared types and constants for the Zorro II autoconfig master.
// The optional bus-cycle timeout is enabled by defining AUTOCFG_TIMEOUT_EN.
package zorro2_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned REG_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MFG_W  = 16;

  // $E80000 expressed on address lines [23:1]; the register number sits in [8:1]
  localparam logic [ADDR_W-1:0] CFG_BASE = 23'h74_0000;

  localparam logic [REG_W-1:0] REG_TYPE   = 8'h00;
  localparam logic [REG_W-1:0] REG_SIZE   = 8'h01;
  localparam logic [REG_W-1:0] REG_MFG0   = 8'h08;
  localparam logic [REG_W-1:0] REG_MFG1   = 8'h09;
  localparam logic [REG_W-1:0] REG_MFG2   = 8'h0A;
  localparam logic [REG_W-1:0] REG_MFG3   = 8'h0B;
  localparam logic [REG_W-1:0] REG_BASE   = 8'h24;
  localparam logic [REG_W-1:0] REG_SHUTUP = 8'h26;

  localparam logic [2:0] SZ_8MB = 3'b000;
  localparam logic [2:0] SZ_4MB = 3'b111;
  localparam logic [2:0] SZ_2MB = 3'b110;
  localparam logic [2:0] SZ_1MB = 3'b101;

  localparam logic [CNT_W-1:0] SLOT_FIRST = 4'h2;
  localparam logic [CNT_W-1:0] SLOT_LIMIT = 4'hA;

  localparam int unsigned TIMEOUT_CLKS = 64;
  localparam int unsigned WR_GUARD     = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_TYPE, ST_RD_SIZE, ST_RD_MFG,
    ST_ALLOC, ST_WR_BASE, ST_WR_SHUTUP, ST_FINISH
  } state_e;

  typedef enum logic [1:0] {BC_IDLE, BC_SETUP, BC_WAIT, BC_HOLD} bc_state_e;

  // Size code to megabytes; 0 marks a code this master cannot place
  function automatic logic [CNT_W-1:0] size_mb(input logic [2:0] code);
    case (code)
      SZ_8MB:  size_mb = 4'd8;
      SZ_4MB:  size_mb = 4'd4;
      SZ_2MB:  size_mb = 4'd2;
      SZ_1MB:  size_mb = 4'd1;
      default: size_mb = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/zorro2_bus_cycle.sv
// Single nibble read/write on the Zorro II config space with DTACKn synchroniser.
// Defining AUTOCFG_TIMEOUT_EN aborts a cycle that sees no DTACKn within TIMEOUT_CLKS.
module zorro2_bus_cycle
  import zorro2_pkg::*;
(
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [REG_W-1:0]  reg_i,
  input  logic [NIB_W-1:0]  wdata_i,
  output logic              ack_o,
  output logic [NIB_W-1:0]  rdata_o,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] ADDR,
  output logic              RWn,
  output logic              ASn,
  output logic              UDSn,
  output logic [NIB_W-1:0]  DOUT,
  input  logic [NIB_W-1:0]  DIN,
  input  logic              DTACKn
);

  bc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rwn_q, rwn_d, as_q, as_d, ack_q, ack_d, tmo_q, tmo_d;
  logic [NIB_W-1:0]  dout_q, dout_d, rdata_q, rdata_d;
  logic [1:0]        sync_q, sync_d;
  logic              expired_c;

`ifdef AUTOCFG_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;

  assign expired_c  = (wait_cnt_q == TMO_W'(TIMEOUT_CLKS - 1));
  assign wait_cnt_d = (state_q == BC_WAIT) ? wait_cnt_q + TMO_W'(1) : '0;

  always_ff @(posedge CLK) begin
    if (!RESETn) wait_cnt_q <= '0;
    else         wait_cnt_q <= wait_cnt_d;
  end
`else
  assign expired_c = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= BC_IDLE;
      addr_q  <= '0;
      rwn_q   <= 1'b1;
      as_q    <= 1'b1;
      ack_q   <= 1'b0;
      tmo_q   <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rwn_q   <= rwn_d;
      as_q    <= as_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      sync_q  <= sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BC_IDLE:  if (req_i) state_d = BC_SETUP;
      BC_SETUP: state_d = BC_WAIT;
      BC_WAIT:  if (!sync_q[1] || expired_c) state_d = BC_HOLD;
      BC_HOLD:  state_d = BC_IDLE;
      default:  state_d = BC_IDLE;
    endcase
  end

  // Synchroniser only runs while strobes are out so a lingering DTACKn cannot leak into the next cycle
  always_comb begin
    addr_d  = addr_q;
    rwn_d   = rwn_q;
    as_d    = as_q;
    ack_d   = 1'b0;
    tmo_d   = tmo_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    sync_d  = 2'b11;
    case (state_q)
      BC_IDLE: if (req_i) begin
        addr_d = CFG_BASE | ADDR_W'(reg_i);
        rwn_d  = ~wr_i;
        dout_d = wr_i ? wdata_i : '0;
        tmo_d  = 1'b0;
      end
      BC_SETUP: as_d = 1'b0;
      BC_WAIT: begin
        sync_d = {sync_q[0], DTACKn};
        if (!sync_q[1]) begin
          rdata_d = DIN;
          as_d    = 1'b1;
        end else if (expired_c) begin
          as_d  = 1'b1;
          tmo_d = 1'b1;
        end
      end
      BC_HOLD: begin
        ack_d = 1'b1;
        rwn_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign timeout_o = tmo_q;
  assign ADDR      = addr_q;
  assign RWn       = rwn_q;
  assign ASn       = as_q;
  assign UDSn      = as_q;
  assign DOUT      = dout_q;

endmodule

// File: rtl/zorro2_autoconfig_master.sv
// Zorro II autoconfig master: walks the CFGIN chain, reads each board and assigns 1MB-aligned bases.
// AUTOCFG_TIMEOUT_EN (in zorro2_bus_cycle) turns an unanswered cycle into end of chain.
module zorro2_autoconfig_master
  import zorro2_pkg::*;
(
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              START,
  output logic [ADDR_W-1:0] ADDR,
  output logic              RWn,
  output logic              ASn,
  output logic              UDSn,
  output logic [NIB_W-1:0]  DOUT,
  input  logic [NIB_W-1:0]  DIN,
  input  logic              DTACKn,
  output logic              CFGOUTn,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [CNT_W-1:0]  BOARD_CNT,
  output logic [CNT_W-1:0]  NEXT_BASE,
  output logic [MFG_W-1:0]  LAST_MFG
);

  localparam int unsigned WCNT_W = $clog2(WR_GUARD) + 1;
  localparam int unsigned CALC_W = CNT_W + 1;

  state_e            state_q, state_d;
  logic              cfgout_q, cfgout_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              issued_q, issued_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, next_q, next_d, size_q, size_d, base_q, base_d;
  logic [MFG_W-1:0]  mfg_q, mfg_d;
  logic [1:0]        idx_q, idx_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic              req_c, wr_c, ack_c, tmo_c, guard_hit_c, fits_c, end_of_chain_c;
  logic [REG_W-1:0]  reg_c;
  logic [NIB_W-1:0]  wdata_c, rdata_c;
  logic [CALC_W-1:0] off_c, mask_c, base_c, end_c;

  zorro2_bus_cycle u_bus (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .req_i     (req_c),
    .wr_i      (wr_c),
    .reg_i     (reg_c),
    .wdata_i   (wdata_c),
    .ack_o     (ack_c),
    .rdata_o   (rdata_c),
    .timeout_o (tmo_c),
    .ADDR      (ADDR),
    .RWn       (RWn),
    .ASn       (ASn),
    .UDSn      (UDSn),
    .DOUT      (DOUT),
    .DIN       (DIN),
    .DTACKn    (DTACKn)
  );

  // Base = NEXT_BASE rounded up so (base - first slot) is a multiple of the size
  assign off_c  = CALC_W'(next_q) - CALC_W'(SLOT_FIRST);
  assign mask_c = CALC_W'(size_q) - CALC_W'(1);
  assign base_c = ((off_c + mask_c) & ~mask_c) + CALC_W'(SLOT_FIRST);
  assign end_c  = base_c + CALC_W'(size_q);
  assign fits_c = (end_c <= CALC_W'(SLOT_LIMIT));

  assign end_of_chain_c = (rdata_c == 4'hF) || (rdata_c[3:2] != 2'b11);
  assign guard_hit_c    = ((state_q == ST_WR_BASE) || (state_q == ST_WR_SHUTUP))
                          && (wcnt_q == WCNT_W'(WR_GUARD));

  // Bus request decode: one request per visit to a bus state
  always_comb begin
    req_c   = 1'b0;
    wr_c    = 1'b0;
    reg_c   = REG_TYPE;
    wdata_c = '0;
    case (state_q)
      ST_RD_TYPE:   req_c = 1'b1;
      ST_RD_SIZE: begin
        req_c = 1'b1;
        reg_c = REG_SIZE;
      end
      ST_RD_MFG: begin
        req_c = 1'b1;
        reg_c = REG_MFG0 + REG_W'(idx_q);
      end
      ST_WR_BASE: begin
        req_c   = ~guard_hit_c;
        wr_c    = 1'b1;
        reg_c   = REG_BASE;
        wdata_c = base_q;
      end
      ST_WR_SHUTUP: begin
        req_c = ~guard_hit_c;
        wr_c  = 1'b1;
        reg_c = REG_SHUTUP;
      end
      default: ;
    endcase
    req_c = req_c & ~issued_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q  <= ST_IDLE;
      cfgout_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      issued_q <= 1'b0;
      cnt_q    <= '0;
      next_q   <= SLOT_FIRST;
      size_q   <= '0;
      base_q   <= '0;
      mfg_q    <= '0;
      idx_q    <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cfgout_q <= cfgout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
      next_q   <= next_d;
      size_q   <= size_d;
      base_q   <= base_d;
      mfg_q    <= mfg_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (START) state_d = ST_RD_TYPE;
      ST_RD_TYPE: if (ack_c) state_d = (tmo_c || end_of_chain_c) ? ST_FINISH : ST_RD_SIZE;
      ST_RD_SIZE: if (ack_c) begin
        if (tmo_c)                         state_d = ST_FINISH;
        else if (size_mb(rdata_c[2:0]) == '0) state_d = ST_WR_SHUTUP;
        else                               state_d = ST_RD_MFG;
      end
      ST_RD_MFG:  if (ack_c) begin
        if (tmo_c)              state_d = ST_FINISH;
        else if (idx_q == 2'd3) state_d = ST_ALLOC;
      end
      ST_ALLOC:   state_d = fits_c ? ST_WR_BASE : ST_WR_SHUTUP;
      ST_WR_BASE, ST_WR_SHUTUP: begin
        if (guard_hit_c) state_d = ST_FINISH;
        else if (ack_c)  state_d = tmo_c ? ST_FINISH : ST_RD_TYPE;
      end
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfgout_d = cfgout_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    issued_d = issued_q;
    cnt_d    = cnt_q;
    next_d   = next_q;
    size_d   = size_q;
    base_d   = base_q;
    mfg_d    = mfg_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    if (req_c) issued_d = 1'b1;
    if (ack_c) issued_d = 1'b0;
    case (state_q)
      ST_IDLE: if (START) begin
        cfgout_d = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = '0;
        next_d   = SLOT_FIRST;
        wcnt_d   = '0;
      end
      ST_RD_SIZE: if (ack_c) begin
        size_d = size_mb(rdata_c[2:0]);
        idx_d  = '0;
      end
      ST_RD_MFG: if (ack_c && !tmo_c) begin
        mfg_d = {mfg_q[MFG_W-NIB_W-1:0], ~rdata_c};
        idx_d = idx_q + 2'd1;
      end
      ST_ALLOC: base_d = base_c[CNT_W-1:0];
      ST_WR_BASE: begin
        if (guard_hit_c) err_d = 1'b1;
        else if (ack_c && !tmo_c) begin
          next_d = base_q + size_q;
          cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_WR_SHUTUP: begin
        if (guard_hit_c) err_d = 1'b1;
        else if (ack_c && !tmo_c) wcnt_d = wcnt_q + WCNT_W'(1);
      end
      ST_FINISH: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign CFGOUTn   = cfgout_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign BOARD_CNT = cnt_q;
  assign NEXT_BASE = next_q;
  assign LAST_MFG  = mfg_q;

endmodule

// File: tb/tb_zorro2_autoconfig_master.sv
// Directed bench for zorro2_autoconfig_master with a small autoconfig board-chain model.
// Covers both builds of AUTOCFG_TIMEOUT_EN.
module tb_zorro2_autoconfig_master;

  logic        CLK = 1'b0;
  logic        RESETn, START;
  logic [22:0] ADDR;
  logic        RWn, ASn, UDSn;
  logic [3:0]  DOUT, DIN;
  logic        DTACKn;
  logic        CFGOUTn, BUSY, DONE, ERR;
  logic [3:0]  BOARD_CNT, NEXT_BASE;
  logic [15:0] LAST_MFG;

  zorro2_autoconfig_master dut (
    .CLK(CLK), .RESETn(RESETn), .START(START), .ADDR(ADDR), .RWn(RWn), .ASn(ASn),
    .UDSn(UDSn), .DOUT(DOUT), .DIN(DIN), .DTACKn(DTACKn), .CFGOUTn(CFGOUTn),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .BOARD_CNT(BOARD_CNT),
    .NEXT_BASE(NEXT_BASE), .LAST_MFG(LAST_MFG)
  );

  always #5 CLK = ~CLK;

  // Board chain: cur is the board currently seeing CFGIN asserted
  logic [3:0]  b_type [4];
  logic [2:0]  b_size [4];
  logic [15:0] b_mfg  [4];
  logic        b_re   [4];
  logic [2:0]  b_resz [4];
  logic [2:0]  nb, cur;
  logic        dtack_stuck;
  logic [11:0] wlog[$];
  bit          prev_as = 1'b1;
  int          as_low;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          ok;

  assign DTACKn = (ASn || dtack_stuck) ? 1'b1 : 1'b0;

  always_comb begin
    DIN = 4'hF;
    if (cur < nb) begin
      case (ADDR[7:0])
        8'h00:   DIN = b_type[cur[1:0]];
        8'h01:   DIN = {1'b0, b_size[cur[1:0]]};
        8'h08:   DIN = ~b_mfg[cur[1:0]][15:12];
        8'h09:   DIN = ~b_mfg[cur[1:0]][11:8];
        8'h0A:   DIN = ~b_mfg[cur[1:0]][7:4];
        8'h0B:   DIN = ~b_mfg[cur[1:0]][3:0];
        default: DIN = 4'hF;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] get_w(input int i);
    if (i < wlog.size()) return wlog[i];
    return 12'hFFF;
  endfunction

  task automatic clr_boards();
    nb = 3'd0;
    cur = 3'd0;
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      b_type[i] = 4'hF; b_size[i] = 3'd0; b_mfg[i] = 16'h0; b_re[i] = 1'b0; b_resz[i] = 3'd0;
    end
  endtask

  task automatic add_board(input logic [3:0] t, input logic [2:0] s, input logic [15:0] m,
                           input logic re, input logic [2:0] rs);
    b_type[nb[1:0]] = t; b_size[nb[1:0]] = s; b_mfg[nb[1:0]] = m;
    b_re[nb[1:0]] = re; b_resz[nb[1:0]] = rs;
    nb = nb + 3'd1;
  endtask

  // One clock; samples 1ns after the edge and logs writes at strobe assertion
  task automatic tick();
    @(posedge CLK);
    #1;
    if (prev_as && !ASn && !RWn) begin
      wlog.push_back({ADDR[7:0], DOUT});
      if (ADDR[7:0] == 8'h24) cur = cur + 3'd1;
      else if (ADDR[7:0] == 8'h26) begin
        if (cur < nb && b_re[cur[1:0]]) b_size[cur[1:0]] = b_resz[cur[1:0]];
        else cur = cur + 3'd1;
      end
    end
    prev_as = ASn;
    if (!ASn) as_low++;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic run(input int budget, output bit seen);
    seen = 1'b0;
    as_low = 0;
    pulse_start();
    for (int i = 0; i < budget; i++) begin
      tick();
      if (DONE) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    RESETn = 1'b0; START = 1'b0; dtack_stuck = 1'b0;
    clr_boards();
    tick(); tick();
    check("rst_asn", 32'(ASn), 32'd1);
    check("rst_udsn", 32'(UDSn), 32'd1);
    check("rst_rwn", 32'(RWn), 32'd1);
    check("rst_cfgout", 32'(CFGOUTn), 32'd1);
    check("rst_addr", 32'(ADDR), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_status", 32'({BUSY, DONE, ERR}), 32'd0);
    check("rst_cnt", 32'(BOARD_CNT), 32'd0);
    check("rst_next", 32'(NEXT_BASE), 32'h2);
    check("rst_mfg", 32'(LAST_MFG), 32'd0);
    RESETn = 1'b1;
    tick();

    // One 8MB board
    clr_boards();
    add_board(4'hE, 3'b000, 16'h1234, 1'b0, 3'd0);
    run(2000, ok);
    check("t1_done_seen", 32'(ok), 32'd1);
    check("t1_nw", 32'(wlog.size()), 32'd1);
    check("t1_w0", 32'(get_w(0)), 32'h242);
    check("t1_cnt", 32'(BOARD_CNT), 32'd1);
    check("t1_next", 32'(NEXT_BASE), 32'hA);
    check("t1_status", 32'({BUSY, DONE, ERR, CFGOUTn}), 32'b0100);
    check("t1_mfg", 32'(LAST_MFG), 32'h1234);

    // Two 4MB boards
    clr_boards();
    add_board(4'hE, 3'b111, 16'h0202, 1'b0, 3'd0);
    add_board(4'hE, 3'b111, 16'h0303, 1'b0, 3'd0);
    run(2000, ok);
    check("t2_done_seen", 32'(ok), 32'd1);
    check("t2_nw", 32'(wlog.size()), 32'd2);
    check("t2_w0", 32'(get_w(0)), 32'h242);
    check("t2_w1", 32'(get_w(1)), 32'h246);
    check("t2_cnt", 32'(BOARD_CNT), 32'd2);
    check("t2_next", 32'(NEXT_BASE), 32'hA);
    check("t2_mfg", 32'(LAST_MFG), 32'h0303);

    // 2MB board, then 8MB board that re-offers 4MB after shutup
    clr_boards();
    add_board(4'hE, 3'b110, 16'h1111, 1'b0, 3'd0);
    add_board(4'hE, 3'b000, 16'h2222, 1'b1, 3'b111);
    run(2000, ok);
    check("t3_done_seen", 32'(ok), 32'd1);
    check("t3_nw", 32'(wlog.size()), 32'd3);
    check("t3_w0", 32'(get_w(0)), 32'h242);
    check("t3_w1", 32'(get_w(1)), 32'h260);
    check("t3_w2", 32'(get_w(2)), 32'h246);
    check("t3_cnt", 32'(BOARD_CNT), 32'd2);
    check("t3_next", 32'(NEXT_BASE), 32'hA);

    // 1MB board with mfg $144A
    clr_boards();
    add_board(4'hE, 3'b101, 16'h144A, 1'b0, 3'd0);
    run(2000, ok);
    check("t4_done_seen", 32'(ok), 32'd1);
    check("t4_mfg", 32'(LAST_MFG), 32'h144A);
    check("t4_w0", 32'(get_w(0)), 32'h242);
    check("t4_next", 32'(NEXT_BASE), 32'h3);
    check("t4_cnt", 32'(BOARD_CNT), 32'd1);

    // Type with bits[3:2] != 11 ends the chain
    clr_boards();
    add_board(4'h8, 3'b000, 16'h5555, 1'b0, 3'd0);
    run(2000, ok);
    check("t5_done_seen", 32'(ok), 32'd1);
    check("t5_nw", 32'(wlog.size()), 32'd0);
    check("t5_cnt", 32'(BOARD_CNT), 32'd0);
    check("t5_next", 32'(NEXT_BASE), 32'h2);
    check("t5_err", 32'(ERR), 32'd0);

    // Unplaceable size code, board then leaves the chain
    clr_boards();
    add_board(4'hE, 3'b011, 16'h6666, 1'b0, 3'd0);
    run(2000, ok);
    check("t6_done_seen", 32'(ok), 32'd1);
    check("t6_nw", 32'(wlog.size()), 32'd1);
    check("t6_w0", 32'(get_w(0)), 32'h260);
    check("t6_cnt", 32'(BOARD_CNT), 32'd0);

    // Board that never accepts shutup trips the write guard
    clr_boards();
    add_board(4'hE, 3'b011, 16'h7777, 1'b1, 3'b011);
    run(3000, ok);
    check("t7_done_seen", 32'(ok), 32'd1);
    check("t7_nw", 32'(wlog.size()), 32'd16);
    check("t7_w15", 32'(get_w(15)), 32'h260);
    check("t7_err", 32'(ERR), 32'd1);
    check("t7_busy", 32'(BUSY), 32'd0);

    // Reset while strobes are asserted
    clr_boards();
    add_board(4'hE, 3'b000, 16'h1234, 1'b0, 3'd0);
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!ASn) break;
    end
    check("t8_as_low", 32'(ASn), 32'd0);
    check("t8_busy_pre", 32'(BUSY), 32'd1);
    RESETn = 1'b0;
    tick();
    check("t8_asn", 32'(ASn), 32'd1);
    check("t8_udsn", 32'(UDSn), 32'd1);
    check("t8_busy", 32'(BUSY), 32'd0);
    check("t8_cnt", 32'(BOARD_CNT), 32'd0);
    check("t8_cfgout", 32'(CFGOUTn), 32'd1);
    RESETn = 1'b1;
    tick();
    run(2000, ok);
    check("t8_rerun_done", 32'(ok), 32'd1);
    check("t8_rerun_cnt", 32'(BOARD_CNT), 32'd1);

    // Empty chain with DTACKn stuck high
    clr_boards();
    dtack_stuck = 1'b1;
`ifdef AUTOCFG_TIMEOUT_EN
    run(300, ok);
    check("t9_done_seen", 32'(ok), 32'd1);
    check("t9_strobe_clks", 32'(as_low), 32'd64);
    check("t9_cnt", 32'(BOARD_CNT), 32'd0);
    check("t9_err", 32'(ERR), 32'd0);
    check("t9_next", 32'(NEXT_BASE), 32'h2);
`else
    pulse_start();
    for (int i = 0; i < 300; i++) tick();
    check("t9_busy", 32'(BUSY), 32'd1);
    check("t9_asn", 32'(ASn), 32'd0);
    check("t9_done", 32'(DONE), 32'd0);
    RESETn = 1'b0;
    tick();
    check("t9_rst_asn", 32'(ASn), 32'd1);
    RESETn = 1'b1;
`endif
    dtack_stuck = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
